// File: rtl/keys_pkg.sv
// Shared definitions for the keys PIO interrupt servicer: register map,
// default key count and the servicer state encoding.
package keys_pkg;

    // Default number of keys on the PIO in_port
    localparam int KEYS_W = 3;

    // PIO register word offsets
    localparam logic [1:0] KEYS_ADDR_DATA = 2'd0;
    localparam logic [1:0] KEYS_ADDR_MASK = 2'd2;
    localparam logic [1:0] KEYS_ADDR_EDGE = 2'd3;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR_MASK,
        ST_RD_CAP,
        ST_CAP_WAIT,
        ST_WR_CLR,
        ST_RD_LVL,
        ST_LVL_WAIT,
        ST_PUSH
    } state_t;

endpackage

// File: rtl/keys_irq_servicer_if.sv
// Avalon-MM link between the servicer (master) and the keys PIO (slave),
// including the PIO's level-sensitive interrupt line.
interface keys_irq_servicer_if;

    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        irq_in;

    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata, irq_in
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata, irq_in
    );

endinterface

// File: rtl/keys_avm_rd.sv
// One-shot read sequencer shared by the edge_capture and data reads.
// A start pulse latches the address and counts READ_LATENCY cycles; done
// is high in the cycle whose readdata must be sampled.
module keys_avm_rd
    import keys_pkg::*;
#(
    parameter int W            = KEYS_W,
    parameter int READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    addr,
    input  logic [31:0]   readdata,
    output logic          done,
    output logic [1:0]    addr_q,
    output logic [W-1:0]  data
);

    localparam int CW = $clog2(READ_LATENCY + 1);

    logic [CW-1:0] cnt;
    logic          active;
    logic          unused_hi;

    // Arm on start, then count down the read latency to the sample cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
            addr_q <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= CW'(READ_LATENCY);
            addr_q <= addr;
        end else if (active) begin
            if (cnt == CW'(1)) begin
                active <= 1'b0;
            end
            cnt <= cnt - CW'(1);
        end
    end

    assign done      = active && (cnt == CW'(1));
    assign data      = readdata[W-1:0];
    assign unused_hi = ^readdata[31:W];

endmodule

// File: rtl/keys_irq_servicer.sv
// Services the keys PIO: programs irq_mask after reset, and on each
// interrupt reads and clears edge_capture, reads the key level and
// presents one event on a valid/ready stream.
module keys_irq_servicer
    import keys_pkg::*;
#(
    parameter int             W            = KEYS_W,
    parameter logic [W-1:0]   INIT_MASK    = '1,
    parameter int             READ_LATENCY = 1,
    parameter int             CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    keys_irq_servicer_if.master  bus,
    input  logic [W-1:0]         mask_wdata,
    input  logic                 mask_load,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [W-1:0]         evt_capture,
    output logic [W-1:0]         evt_level,
    output logic [CNT_W-1:0]     evt_count,
    output logic                 busy
);

    state_t         state;
    logic           mask_pend;
    logic [W-1:0]   mask_val;
    logic [W-1:0]   cap_reg;
    logic           rd_start;
    logic           rd_done;
    logic [1:0]     rd_addr;
    logic [W-1:0]   rd_data;

    assign rd_start = (state == ST_RD_CAP) || (state == ST_RD_LVL);

    keys_avm_rd #(
        .W            (W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd (
        .clk      (clk),
        .reset    (reset),
        .start    (rd_start),
        .addr     (bus.avm_address),
        .readdata (bus.avm_readdata),
        .done     (rd_done),
        .addr_q   (rd_addr),
        .data     (rd_data)
    );

    // Keep the edge_capture word; the level word goes straight to evt_level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_reg <= '0;
        end else if (rd_done && rd_addr == KEYS_ADDR_EDGE) begin
            cap_reg <= rd_data;
        end
    end

    // Servicer FSM; bus and stream outputs are registered on state entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_INIT;
            bus.avm_chipselect <= 1'b0;
            bus.avm_write_n    <= 1'b1;
            bus.avm_address    <= KEYS_ADDR_DATA;
            bus.avm_writedata  <= '0;
            busy               <= 1'b1;
            mask_pend          <= 1'b0;
            mask_val           <= '0;
            evt_valid          <= 1'b0;
            evt_capture        <= '0;
            evt_level          <= '0;
            evt_count          <= '0;
        end else begin
            // NOTE: later non-blocking writes to mask_pend below override this set, so each clear is guarded by !mask_load.
            if (mask_load) begin
                mask_pend <= 1'b1;
                mask_val  <= mask_wdata;
            end
            case (state)
                ST_INIT: begin
                    // NOTE: outputs are registered, so the first cycle after reset is bus-idle and the mask write follows it.
                    if (!bus.avm_chipselect) begin
                        bus.avm_chipselect <= 1'b1;
                        bus.avm_write_n    <= 1'b0;
                        bus.avm_address    <= KEYS_ADDR_MASK;
                        bus.avm_writedata  <= 32'(INIT_MASK);
                    end else begin
                        state              <= ST_IDLE;
                        bus.avm_chipselect <= 1'b0;
                        bus.avm_write_n    <= 1'b1;
                        bus.avm_address    <= KEYS_ADDR_DATA;
                        bus.avm_writedata  <= '0;
                        busy               <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    // A load arriving this very cycle counts as pending and its value is written
                    if (mask_pend || mask_load) begin
                        state              <= ST_WR_MASK;
                        bus.avm_chipselect <= 1'b1;
                        bus.avm_write_n    <= 1'b0;
                        bus.avm_address    <= KEYS_ADDR_MASK;
                        bus.avm_writedata  <= 32'(mask_load ? mask_wdata : mask_val);
                        busy               <= 1'b1;
                    end else if (bus.irq_in) begin
                        state              <= ST_RD_CAP;
                        bus.avm_chipselect <= 1'b1;
                        bus.avm_write_n    <= 1'b1;
                        bus.avm_address    <= KEYS_ADDR_EDGE;
                        busy               <= 1'b1;
                    end
                end
                ST_WR_MASK: begin
                    if (!mask_load) begin
                        mask_pend <= 1'b0;
                    end
                    state              <= ST_IDLE;
                    bus.avm_chipselect <= 1'b0;
                    bus.avm_write_n    <= 1'b1;
                    bus.avm_address    <= KEYS_ADDR_DATA;
                    bus.avm_writedata  <= '0;
                    busy               <= 1'b0;
                end
                ST_RD_CAP: begin
                    state <= ST_CAP_WAIT;
                end
                ST_CAP_WAIT: begin
                    if (rd_done) begin
                        state             <= ST_WR_CLR;
                        bus.avm_write_n   <= 1'b0;
                        bus.avm_writedata <= 32'(rd_data);
                    end
                end
                ST_WR_CLR: begin
                    state             <= ST_RD_LVL;
                    bus.avm_write_n   <= 1'b1;
                    bus.avm_address   <= KEYS_ADDR_DATA;
                    bus.avm_writedata <= '0;
                end
                ST_RD_LVL: begin
                    state <= ST_LVL_WAIT;
                end
                ST_LVL_WAIT: begin
                    if (rd_done) begin
                        bus.avm_chipselect <= 1'b0;
                        bus.avm_address    <= KEYS_ADDR_DATA;
                        if (cap_reg != '0) begin
                            state       <= ST_PUSH;
                            evt_valid   <= 1'b1;
                            evt_capture <= cap_reg;
                            evt_level   <= rd_data;
                        end else begin
                            // Spurious interrupt: nothing captured, no event
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_PUSH: begin
                    if (evt_ready) begin
                        state     <= ST_IDLE;
                        evt_valid <= 1'b0;
                        evt_count <= evt_count + CNT_W'(1);
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: doc/keys_irq_servicer.md
Name: keys_irq_servicer

Overview:
- Avalon-MM initiator that services the 3-bit keys PIO responder.
- On reset release it programs the PIO's irq_mask register.
- On each PIO interrupt it reads edge_capture, clears it, then reads the live key level.
- It presents one key event per interrupt on a valid/ready stream to downstream video-control logic, removing key handling from software.

Parameters:
- W, 3, key count; must equal the PIO in_port width.
- INIT_MASK, 3'b111, irq_mask value written after reset.
- READ_LATENCY, 1, cycles from read address presented to readdata valid; legal range 1..4.
- CNT_W, 16, event counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- avm_address  out  2  PIO register word offset: 0 data, 2 irq_mask, 3 edge_capture
- avm_chipselect  out  1  bus cycle active
- avm_write_n  out  1  0 = write, 1 = read
- avm_writedata  out  32  write data
- avm_readdata  in  32  PIO read data
- irq_in  in  1  PIO interrupt, level-sensitive
- mask_wdata  in  W  new irq_mask value
- mask_load  in  1  one-cycle request to rewrite irq_mask
- evt_valid  out  1  event available
- evt_ready  in  1  downstream accepts the event
- evt_capture  out  W  edge_capture bits for this event
- evt_level  out  W  key level sampled after the clear
- evt_count  out  CNT_W  accepted-event counter
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: avm_chipselect 0, avm_write_n 1, avm_address 0, avm_writedata 0, evt_valid 0, evt_capture 0, evt_level 0, evt_count 0, busy 1, mask_pend 0, state INIT.
- Reset asserted in any state, including mid bus cycle or mid handshake: outputs return to reset values immediately. After release the FSM restarts at INIT.
- avm_chipselect is 1 only in INIT, WR_MASK, RD_CAP, CAP_WAIT, WR_CLR, RD_LVL and LVL_WAIT.
- Read states hold avm_address stable with avm_write_n = 1.
- Write states last exactly one cycle with avm_write_n = 0. Upper bits of writedata are 0.
- States and transitions:
  - INIT: write addr 2, data INIT_MASK -> IDLE.
  - IDLE (busy 0): if mask_pend -> WR_MASK; else if irq_in -> RD_CAP. Mask rewrite has priority over irq.
  - WR_MASK: write addr 2, data mask_wdata latched at mask_load; clear mask_pend -> IDLE.
  - RD_CAP: address 3, one cycle -> CAP_WAIT.
  - CAP_WAIT: address 3 held for READ_LATENCY cycles. On the last cycle, sample avm_readdata[W-1:0] into cap_reg -> WR_CLR.
  - WR_CLR: write addr 3, data cap_reg. The PIO clears all edge_capture bits regardless of data -> RD_LVL.
  - RD_LVL / LVL_WAIT: same timing as RD_CAP / CAP_WAIT with address 0. Sample into lvl_reg. Then -> PUSH if cap_reg != 0, else -> IDLE (spurious irq, no event, no count).
  - PUSH: evt_valid = 1, evt_capture = cap_reg, evt_level = lvl_reg, all stable until evt_ready. On a cycle with valid & ready: evt_count += 1 (wraps modulo 2^CNT_W) -> IDLE.
- Latency (READ_LATENCY = 1):
  - irq_in sampled high in IDLE at T0.
  - RD_CAP T1, sample T2, WR_CLR T3, RD_LVL T4, sample T5.
  - evt_valid rises at T6.
  - With evt_ready held high, back in IDLE at T7.
- mask_load:
  - Accepted in any state. It sets mask_pend and latches mask_wdata.
  - A second mask_load before the rewrite overwrites the latched value; last value wins.
  - mask_load in the same cycle as the WR_MASK write re-arms mask_pend with the new value.
- Edges arriving between the CAP_WAIT sample and WR_CLR are lost; this is a PIO property and is accepted.
- Edges arriving after WR_CLR re-raise irq_in and are serviced on the next IDLE visit.
- irq_in is ignored outside IDLE.
- No backpressure timeout: PUSH waits indefinitely, and further interrupts stay pending in the PIO.

Decomposition:
- Shared package keys_pkg:
  - register offsets KEYS_ADDR_DATA = 0, KEYS_ADDR_MASK = 2, KEYS_ADDR_EDGE = 3
  - state enum typedef
  - default W
- Sub-module keys_avm_rd: a one-shot read sequencer. It takes start and addr, counts READ_LATENCY, and returns done plus sampled data. It is instantiated once and shared by the capture and level reads.
- Everything else stays in the top level.

Test Plan:
- Reset release -> exactly one write: addr 2, writedata 0x7, then busy = 0. Reset pulse mid CAP_WAIT -> chipselect 0 the same cycle, INIT write repeats after release.
- Behavioural PIO model; press key1 (in_port 3'b000 -> 3'b010 -> 3'b000) with evt_ready = 1 -> evt_valid at T6 with evt_capture 3'b010 and evt_level 3'b000, one addr 3 write, evt_count 1, irq_in low by T5.
- Hold evt_ready = 0 for 20 cycles, then press key2 during PUSH -> first event held stable. After ready, a second event with capture 3'b100 follows and evt_count is 2.
- mask_load with 3'b001 asserted in the same cycle as irq_in high in IDLE -> WR_MASK (addr 2, data 0x1) precedes RD_CAP. Later key2 press -> no irq, no event.
- Force irq_in high while the model returns edge_capture 0 -> sequence runs through RD_LVL, no evt_valid, evt_count unchanged.
- READ_LATENCY = 3 build, model delayed to match -> sample taken on the third wait cycle, evt_valid rises 4 cycles later than the READ_LATENCY = 1 case, values correct.
